// File: rtl/csr_file.sv
// Machine-mode CSR file: debug CSR, scratch bank, 64-bit cycle/instret counters
// with read-only shadows. Requests are sampled on a rising edge; results are registered.
module csr_file #(
  parameter int          XLEN         = 32,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [11:0] SCRATCH_BASE = 12'h340,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [2:0]      csr_op,
  input  logic [4:0]      csr_uimm,
  input  logic            csr_src_zero,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_data_out,
  output logic            csr_valid,
  output logic            csr_illegal
);

  logic [XLEN-1:0]                  dbg_q, dbg_d;
  logic [NUM_SCRATCH-1:0][XLEN-1:0] scr_q, scr_d;
  logic [63:0]                      cyc_q, cyc_d, ins_q, ins_d;
  logic [XLEN-1:0]                  data_q, data_d;
  logic                             valid_q, illegal_q;

  logic [11:0]     sidx;
  logic            sel_dbg, sel_scr, sel_cyc_lo, sel_cyc_hi, sel_ins_lo, sel_ins_hi;
  logic            mapped, do_wr, illegal, commit;
  logic [XLEN-1:0] src, rdata, wdata;

  always_comb begin
    sidx       = csr_addr - SCRATCH_BASE;
    sel_dbg    = (csr_addr == 12'h309);
    sel_scr    = !sel_dbg && (sidx < 12'(NUM_SCRATCH));
    sel_cyc_lo = HAS_COUNTERS && (csr_addr == 12'hB00);
    sel_cyc_hi = HAS_COUNTERS && (csr_addr == 12'hB80);
    sel_ins_lo = HAS_COUNTERS && (csr_addr == 12'hB02);
    sel_ins_hi = HAS_COUNTERS && (csr_addr == 12'hB82);
    rdata      = '0;
    mapped     = 1'b1;
    if (sel_dbg) rdata = dbg_q;
    else if (sel_scr) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (sidx == 12'(i)) rdata = scr_q[i];
    end
    else if (sel_cyc_lo) rdata = cyc_q[31:0];
    else if (sel_cyc_hi) rdata = cyc_q[63:32];
    else if (sel_ins_lo) rdata = ins_q[31:0];
    else if (sel_ins_hi) rdata = ins_q[63:32];
    // User shadows alias the machine counters; writes fall out as illegal below.
    else if (HAS_COUNTERS && csr_addr == 12'hC00) rdata = cyc_q[31:0];
    else if (HAS_COUNTERS && csr_addr == 12'hC80) rdata = cyc_q[63:32];
    else if (HAS_COUNTERS && csr_addr == 12'hC02) rdata = ins_q[31:0];
    else if (HAS_COUNTERS && csr_addr == 12'hC82) rdata = ins_q[63:32];
    else mapped = 1'b0;

    src = csr_op[2] ? {{(XLEN-5){1'b0}}, csr_uimm} : csr_data_in;
    case (csr_op[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = rdata | src;
      2'b11:   wdata = rdata & ~src;
      default: wdata = rdata;
    endcase
    do_wr   = csr_en && ((csr_op[1:0] == 2'b01) || (csr_op[1] && !csr_src_zero));
    illegal = csr_en && (!mapped || (do_wr && csr_addr[11:10] == 2'b11));
    commit  = do_wr && !illegal;
  end

  always_comb begin
    dbg_d = dbg_q;
    scr_d = scr_q;
    if (commit && sel_dbg) dbg_d = wdata;
    if (commit && sel_scr) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (sidx == 12'(i)) scr_d[i] = wdata;
    end
    // A written half overrides; the other half keeps its normal increment,
    // so a carry into a written high half is lost.
    cyc_d = cyc_q + 64'd1;
    ins_d = ins_q + {63'd0, instr_retire};
    if (commit && sel_cyc_lo) cyc_d[31:0]  = wdata;
    if (commit && sel_cyc_hi) cyc_d[63:32] = wdata;
    if (commit && sel_ins_lo) ins_d[31:0]  = wdata;
    if (commit && sel_ins_hi) ins_d[63:32] = wdata;
    if (!HAS_COUNTERS) begin
      cyc_d = '0;
      ins_d = '0;
    end
    data_d = data_q;
    if (csr_en) data_d = illegal ? '0 : rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_q     <= '0;
      scr_q     <= '0;
      cyc_q     <= '0;
      ins_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      dbg_q     <= dbg_d;
      scr_q     <= scr_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
      data_q    <= data_d;
      valid_q   <= csr_en;
      illegal_q <= illegal;
    end
  end

  assign csr_data_out = data_q;
  assign csr_valid    = valid_q;
  assign csr_illegal  = illegal_q;

endmodule
